// File: rtl/pc_pkg.sv
// Shared types and default constants for the fetch-stage PC generator.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_BOOT   = 2'd0,
    PC_RUN    = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_e;

  localparam int unsigned PC_W_DEF      = 8;
  localparam int unsigned STEP_DEF      = 1;
  localparam int unsigned RESET_VEC_DEF = 32'h0000_0000;
  localparam int unsigned TRAP_VEC_DEF  = 32'h0000_00F0;
  localparam int unsigned RAS_DEPTH_DEF = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: top pointer plus saturating occupancy count.
// A push into a full stack silently overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned W     = PC_W_DEF,
  parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         overflow
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] cnt;
  logic [PTR_W-1:0] wr_ptr_c;

  assign wr_ptr_c = top_ptr + PTR_W'(1);
  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(DEPTH));
  assign top      = mem[top_ptr];

  // Stack storage, pointer and count update; overflow pulses the cycle after a push into a full stack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_ptr  <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      overflow <= push && full;
      if (push) begin
        mem[wr_ptr_c] <= push_data;
        top_ptr       <= wr_ptr_c;
        if (!full) begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (pop && !empty) begin
        top_ptr <= top_ptr - PTR_W'(1);
        cnt     <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: BOOT/RUN/HALTED FSM, trap/redirect/halt
// priority mux, valid/ready handshake toward fetch and call/return prediction.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter int unsigned STEP      = STEP_DEF,
  parameter int unsigned RESET_VEC = RESET_VEC_DEF,
  parameter int unsigned TRAP_VEC  = TRAP_VEC_DEF,
  parameter int unsigned RAS_DEPTH = RAS_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  input  logic            fetch_ready,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            trap,
  input  logic            halt,
  input  logic            call,
  input  logic [PC_W-1:0] call_pc,
  input  logic            ret,
  output logic            ras_overflow,
  output logic            ras_underflow
);

  localparam logic [PC_W-1:0] RESET_PC = PC_W'(RESET_VEC);
  localparam logic [PC_W-1:0] TRAP_PC  = PC_W'(TRAP_VEC);
  localparam logic [PC_W-1:0] STEP_PC  = PC_W'(STEP);

  pc_state_e       state, state_d;
  logic [PC_W-1:0] pc_d;
  logic            valid_d;
  logic            underflow_d;
  logic            accept_c;
  logic [PC_W-1:0] pc_next_seq_c;
  logic            ras_push_c;
  logic            ras_pop_c;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;

  assign accept_c      = pc_valid && fetch_ready;
  assign pc_next_seq_c = pc_out + STEP_PC;

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push_c),
    .pop       (ras_pop_c),
    .push_data (pc_next_seq_c),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full),
    .overflow  (ras_overflow)
  );

  // State, PC and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= PC_BOOT;
      pc_out        <= RESET_PC;
      pc_valid      <= 1'b0;
      ras_underflow <= 1'b0;
    end else begin
      state         <= state_d;
      pc_out        <= pc_d;
      pc_valid      <= valid_d;
      ras_underflow <= underflow_d;
    end
  end

  // Next-state and next-PC selection, trap > redirect > halt > stall > ret > call > sequential
  always_comb begin
    state_d     = state;
    pc_d        = pc_out;
    valid_d     = 1'b0;
    underflow_d = 1'b0;
    ras_push_c  = 1'b0;
    ras_pop_c   = 1'b0;
    unique case (state)
      PC_BOOT: begin
        state_d = PC_RUN;
      end
      PC_RUN: begin
        if (trap) begin
          pc_d = TRAP_PC;
        end else if (redirect_valid) begin
          pc_d = redirect_pc;
        end else if (halt) begin
          state_d = PC_HALTED;
        end else if (accept_c) begin
          if (ret) begin
            if (!ras_empty) begin
              pc_d      = ras_top;
              ras_pop_c = 1'b1;
            end else begin
              pc_d        = pc_next_seq_c;
              underflow_d = 1'b1;
            end
          end else if (call) begin
            ras_push_c = 1'b1;
            pc_d       = call_pc;
          end else begin
            pc_d = pc_next_seq_c;
          end
        end
      end
      PC_HALTED: begin
        if (trap) begin
          pc_d    = TRAP_PC;
          state_d = PC_RUN;
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = PC_RUN;
        end
      end
      default: begin
        state_d = PC_BOOT;
      end
    endcase
    valid_d = (state_d == PC_RUN);
  end

  // An overflow pulse can only follow a push made while the stack was full
  a_ovf_needs_full: assert property (@(posedge clk) disable iff (!rst_n)
    ras_overflow |-> $past(ras_full));

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed vector table, reset corner cases and a random run
// compared against a queue-based reference model.
module tb_pc_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] pc_out;
  logic       pc_valid;
  logic       fetch_ready = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [7:0] redirect_pc = 8'h00;
  logic       trap = 1'b0;
  logic       halt = 1'b0;
  logic       call = 1'b0;
  logic [7:0] call_pc = 8'h00;
  logic       ret = 1'b0;
  logic       ras_overflow;
  logic       ras_underflow;

  int n_checks = 0;
  int n_errors = 0;

  pc_gen #(
    .PC_W      (8),
    .STEP      (1),
    .RESET_VEC (0),
    .TRAP_VEC  (32'hF0),
    .RAS_DEPTH (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_out         (pc_out),
    .pc_valid       (pc_valid),
    .fetch_ready    (fetch_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap           (trap),
    .halt           (halt),
    .call           (call),
    .call_pc        (call_pc),
    .ret            (ret),
    .ras_overflow   (ras_overflow),
    .ras_underflow  (ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       trp;
    logic       hlt;
    logic       cal;
    logic [7:0] cpc;
    logic       rt;
    logic [7:0] e_pc;
    logic       e_valid;
    logic       e_ovf;
    logic       e_unf;
  } vec_t;

  vec_t tbl[$];

  // Reference model: mode flags, PC and the RAS as a bounded queue (newest at back)
  bit         m_boot;
  bit         m_halted;
  logic [7:0] m_pc;
  bit         m_valid;
  bit         m_ovf;
  bit         m_unf;
  logic [7:0] m_ras[$];

  function automatic void model_reset();
    m_boot   = 1'b1;
    m_halted = 1'b0;
    m_pc     = 8'h00;
    m_valid  = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_ras.delete();
  endfunction

  function automatic void model_step();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    if (m_boot) begin
      m_boot  = 1'b0;
      m_valid = 1'b1;
    end else if (m_halted) begin
      if (trap) begin
        m_pc = 8'hF0; m_halted = 1'b0; m_valid = 1'b1;
      end else if (redirect_valid) begin
        m_pc = redirect_pc; m_halted = 1'b0; m_valid = 1'b1;
      end
    end else begin
      if (trap) m_pc = 8'hF0;
      else if (redirect_valid) m_pc = redirect_pc;
      else if (halt) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (!fetch_ready) begin
        // stalled: nothing changes
      end else if (ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back();
        else begin
          m_pc = m_pc + 8'd1; m_unf = 1'b1;
        end
      end else if (call) begin
        m_ras.push_back(m_pc + 8'd1);
        if (m_ras.size() > 4) begin
          void'(m_ras.pop_front());
          m_ovf = 1'b1;
        end
        m_pc = call_pc;
      end else begin
        m_pc = m_pc + 8'd1;
      end
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    fetch_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00; trap = 1'b0;
    halt = 1'b0; call = 1'b0; call_pc = 8'h00; ret = 1'b0;
  endtask

  // Apply one cycle of inputs (called at a negedge); returns at the following negedge
  task automatic drive(input vec_t t);
    fetch_ready = t.rdy; redirect_valid = t.redir; redirect_pc = t.rpc; trap = t.trp;
    halt = t.hlt; call = t.cal; call_pc = t.cpc; ret = t.rt;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc_out), 32'h00);
    check("rst_valid", 32'(pc_valid), 32'h0);
    rst_n = 1'b1;
  endtask

  function automatic void add(input logic rdy, input logic redir, input logic [7:0] rpc,
                              input logic trp, input logic hlt, input logic cal,
                              input logic [7:0] cpc, input logic rt, input logic [7:0] e_pc,
                              input logic e_valid, input logic e_ovf, input logic e_unf);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc; v.trp = trp; v.hlt = hlt;
    v.cal = cal; v.cpc = cpc; v.rt = rt;
    v.e_pc = e_pc; v.e_valid = e_valid; v.e_ovf = e_ovf; v.e_unf = e_unf;
    tbl.push_back(v);
  endfunction

  function automatic vec_t idle(input logic rdy);
    vec_t v;
    v.rdy = rdy; v.redir = 1'b0; v.rpc = 8'h00; v.trp = 1'b0; v.hlt = 1'b0;
    v.cal = 1'b0; v.cpc = 8'h00; v.rt = 1'b0;
    v.e_pc = 8'h00; v.e_valid = 1'b0; v.e_ovf = 1'b0; v.e_unf = 1'b0;
    return v;
  endfunction

  initial begin
    vec_t v;
    //   rdy rdr rpc    trp hlt cal cpc    ret  pc     vld ovf unf
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);  // boot cycle ends
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h01, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h02, 1, 0, 0);
    add(0, 1, 8'hFE, 0, 0, 0, 8'h00, 0, 8'hFE, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'hFF, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);  // wrap
    add(0, 1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h05, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h05, 1, 0, 0);  // stall x3
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h05, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h05, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h06, 1, 0, 0);
    add(0, 1, 8'h40, 1, 0, 0, 8'h00, 0, 8'hF0, 1, 0, 0);  // trap beats redirect
    add(0, 1, 8'h40, 0, 0, 0, 8'h00, 0, 8'h40, 1, 0, 0);
    add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h40, 0, 0, 0);  // halt
    add(1, 0, 8'h00, 0, 1, 1, 8'h77, 0, 8'h40, 0, 0, 0);  // halted ignores halt/call
    add(0, 1, 8'h20, 0, 0, 0, 8'h00, 0, 8'h20, 1, 0, 0);
    add(0, 1, 8'h10, 0, 0, 0, 8'h00, 0, 8'h10, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h80, 0, 8'h80, 1, 0, 0);  // call
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h81, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0);  // ret
    add(0, 1, 8'h30, 0, 0, 0, 8'h00, 0, 8'h30, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h31, 1, 0, 1);  // empty ret
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h32, 1, 0, 0);
    add(0, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h32, 1, 0, 0);  // unaccepted ret
    add(0, 0, 8'h00, 0, 0, 1, 8'h55, 0, 8'h32, 1, 0, 0);  // unaccepted call
    add(1, 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h32, 0, 0, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 8'hF0, 1, 0, 0);  // trap leaves halt
    add(0, 1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h10, 0, 8'h10, 1, 0, 0);  // five nested calls
    add(1, 0, 8'h00, 0, 0, 1, 8'h20, 0, 8'h20, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h30, 0, 8'h30, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h40, 0, 8'h40, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 1, 8'h50, 0, 8'h50, 1, 1, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h41, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h31, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h21, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h11, 1, 0, 0);
    add(1, 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h12, 1, 0, 1);
    add(1, 0, 8'h00, 0, 0, 1, 8'h99, 1, 8'h13, 1, 0, 1);  // call+ret: ret wins

    #2;
    check("async_rst_pc", 32'(pc_out), 32'h00);
    check("async_rst_valid", 32'(pc_valid), 32'h0);
    @(negedge clk);
    do_reset();

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check($sformatf("tbl%0d_pc", i), 32'(pc_out), 32'(tbl[i].e_pc));
      check($sformatf("tbl%0d_valid", i), 32'(pc_valid), 32'(tbl[i].e_valid));
      check($sformatf("tbl%0d_ovf", i), 32'(ras_overflow), 32'(tbl[i].e_ovf));
      check($sformatf("tbl%0d_unf", i), 32'(ras_underflow), 32'(tbl[i].e_unf));
    end

    // Reset between edges while halted with RAS entries present
    v = idle(1'b0); v.redir = 1'b1; v.rpc = 8'h60; drive(v);
    v = idle(1'b1); v.cal = 1'b1; v.cpc = 8'h70; drive(v);
    check("mid_call_pc", 32'(pc_out), 32'h70);
    v = idle(1'b1); v.hlt = 1'b1; drive(v);
    check("mid_halt_valid", 32'(pc_valid), 32'h0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_pc", 32'(pc_out), 32'h00);
    check("mid_rst_valid", 32'(pc_valid), 32'h0);
    check("mid_rst_ovf", 32'(ras_overflow), 32'h0);
    check("mid_rst_unf", 32'(ras_underflow), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(idle(1'b1));
    check("reboot_pc", 32'(pc_out), 32'h00);
    check("reboot_valid", 32'(pc_valid), 32'h1);
    v = idle(1'b1); v.rt = 1'b1; drive(v);
    check("reboot_ret_pc", 32'(pc_out), 32'h01);
    check("reboot_ret_unf", 32'(ras_underflow), 32'h1);

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      v.rdy   = ($urandom_range(99) < 70);
      v.redir = ($urandom_range(99) < 5);
      v.rpc   = 8'($urandom);
      v.trp   = ($urandom_range(99) < 3);
      v.hlt   = ($urandom_range(99) < 4);
      v.cal   = ($urandom_range(99) < 20);
      v.cpc   = 8'($urandom);
      v.rt    = ($urandom_range(99) < 18);
      drive(v);
      check($sformatf("rnd%0d_pc", n), 32'(pc_out), 32'(m_pc));
      check($sformatf("rnd%0d_valid", n), 32'(pc_valid), 32'(m_valid));
      check($sformatf("rnd%0d_ovf", n), 32'(ras_overflow), 32'(m_ovf));
      check($sformatf("rnd%0d_unf", n), 32'(ras_underflow), 32'(m_unf));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
